// File: rtl/eqn_pkg.sv
// eqn_pkg: shared types and helpers for the eqn_reduce_stretch block.
//   eqn_mode_e : reduction mode selected at run time through mode_i.
//   eqn_cw()   : width of the stretch counter needed to hold STRETCH.
package eqn_pkg;

  typedef enum logic [1:0] {
    EQN_OR     = 2'b00,
    EQN_AND    = 2'b01,
    EQN_XOR    = 2'b10,
    EQN_STICKY = 2'b11
  } eqn_mode_e;

  // The counter must hold values 0..stretch. A zero stretch still gets a
  // one-bit counter so that no zero-width vectors appear anywhere.
  function automatic int eqn_cw(input int stretch);
    return (stretch < 1) ? 1 : $clog2(stretch + 1);
  endfunction

endpackage

// File: rtl/eqn_stretch.sv
// eqn_stretch: registers a reduction result and holds it high for STRETCH
// extra cycles after it falls.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   en     : update enable; 0 holds cnt_q and yo, and forces rise_o low
//   raw    : combinational reduction result to register and stretch
//   yo     : registered, stretched result
//   rise_o : one-cycle pulse on the first high cycle of yo
//   busy_o : stretch counter non-zero
module eqn_stretch
  import eqn_pkg::*;
#(
  parameter int STRETCH = 0,
  parameter int CW      = eqn_cw(STRETCH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en,
  input  logic raw,
  output logic yo,
  output logic rise_o,
  output logic busy_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          yo_d;

  // A high raw reloads the full stretch; otherwise the counter drains and
  // yo stays high until it has reached zero.
  always_comb begin
    cnt_d = cnt_q;
    yo_d  = 1'b0;
    if (raw) begin
      cnt_d = CW'(STRETCH);
      yo_d  = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      yo_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      yo     <= 1'b0;
      rise_o <= 1'b0;
    end else if (en) begin
      cnt_q  <= cnt_d;
      yo     <= yo_d;
      // Retriggering while yo is already high gives no new pulse.
      rise_o <= ~yo & yo_d;
    end else begin
      rise_o <= 1'b0;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/eqn_reduce_stretch.sv
// eqn_reduce_stretch: registered WIDTH-input reduction (OR, AND, XOR or
// sticky-OR) with optional pulse stretching.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   en_i   : update enable; 0 freezes all state and ignores clr_i
//   mode_i : 00 OR, 01 AND, 10 XOR, 11 sticky-OR
//   in_i   : WIDTH inputs to reduce
//   clr_i  : clears the sticky latch
//   yo     : registered, stretched result
//   rise_o : one-cycle pulse when yo goes 0->1
//   busy_o : stretch counter non-zero
module eqn_reduce_stretch
  import eqn_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int STRETCH = 0,
  parameter int CW      = eqn_cw(STRETCH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             clr_i,
  output logic             yo,
  output logic             rise_o,
  output logic             busy_o
);

  logic any_in;
  logic sticky_q;
  logic raw;

  assign any_in = |in_i;

  // In sticky mode the current inputs are ORed in directly, so a cycle
  // that both clears and sets the latch still reports its own input.
  always_comb begin
    raw = 1'b0;
    case (eqn_mode_e'(mode_i))
      EQN_OR:     raw = any_in;
      EQN_AND:    raw = &in_i;
      EQN_XOR:    raw = ^in_i;
      EQN_STICKY: raw = sticky_q | any_in;
      default:    raw = 1'b0;
    endcase
  end

  // The latch tracks inputs in every mode so it is already armed when the
  // mode switches to sticky. Clear wins over a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        sticky_q <= 1'b0;
      end else if (any_in) begin
        sticky_q <= 1'b1;
      end
    end
  end

  eqn_stretch #(
    .STRETCH (STRETCH),
    .CW      (CW)
  ) u_stretch (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (en_i),
    .raw    (raw),
    .yo     (yo),
    .rise_o (rise_o),
    .busy_o (busy_o)
  );

endmodule

// File: tb/tb_eqn_reduce_stretch.sv
// Directed bench for eqn_reduce_stretch. Three instances share all inputs:
// a (STRETCH=0), b (STRETCH=3) and c (STRETCH=5), all WIDTH=4.
module tb_eqn_reduce_stretch;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] in_v;
  logic       clr;

  logic a_yo, a_rise, a_busy;
  logic b_yo, b_rise, b_busy;
  logic c_yo, c_rise, c_busy;

  int checks = 0;
  int errors = 0;

  eqn_reduce_stretch #(.WIDTH(4), .STRETCH(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .in_i(in_v),
    .clr_i(clr), .yo(a_yo), .rise_o(a_rise), .busy_o(a_busy)
  );

  eqn_reduce_stretch #(.WIDTH(4), .STRETCH(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .in_i(in_v),
    .clr_i(clr), .yo(b_yo), .rise_o(b_rise), .busy_o(b_busy)
  );

  eqn_reduce_stretch #(.WIDTH(4), .STRETCH(5)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .in_i(in_v),
    .clr_i(clr), .yo(c_yo), .rise_o(c_rise), .busy_o(c_busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one active edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; in_v = 4'b0000; clr = 1'b0;
    steps(3);
    chk("rst a_yo", a_yo, 1'b0);
    chk("rst a_rise", a_rise, 1'b0);
    chk("rst a_busy", a_busy, 1'b0);
    chk("rst b_yo", b_yo, 1'b0);
    chk("rst b_busy", b_busy, 1'b0);
    chk("rst c_yo", c_yo, 1'b0);
    rst_n = 1'b1;

    // plain registered OR on a
    in_v = 4'b0000; step();
    chk("or00 yo", a_yo, 1'b0);
    in_v = 4'b0001; step();
    chk("or01 yo", a_yo, 1'b1);
    chk("or01 rise", a_rise, 1'b1);
    chk("or01 b_busy", b_busy, 1'b1);
    in_v = 4'b0010; step();
    chk("or10 yo", a_yo, 1'b1);
    chk("or10 rise", a_rise, 1'b0);
    in_v = 4'b0011; step();
    chk("or11 yo", a_yo, 1'b1);
    chk("or11 rise", a_rise, 1'b0);
    in_v = 4'b0000; step();
    chk("or00b yo", a_yo, 1'b0);
    chk("or00b rise", a_rise, 1'b0);
    chk("or00b b_yo", b_yo, 1'b1);
    steps(5);

    // STRETCH=3 single pulse on b: yo high 4 cycles, busy 3
    in_v = 4'b0001; step();
    chk("s3 h1 yo", b_yo, 1'b1);
    chk("s3 h1 rise", b_rise, 1'b1);
    chk("s3 h1 busy", b_busy, 1'b1);
    in_v = 4'b0000; step();
    chk("s3 h2 yo", b_yo, 1'b1);
    chk("s3 h2 rise", b_rise, 1'b0);
    chk("s3 h2 busy", b_busy, 1'b1);
    step();
    chk("s3 h3 busy", b_busy, 1'b1);
    step();
    chk("s3 h4 yo", b_yo, 1'b1);
    chk("s3 h4 busy", b_busy, 1'b0);
    step();
    chk("s3 end yo", b_yo, 1'b0);
    chk("s3 end busy", b_busy, 1'b0);

    // retrigger on the 3rd high cycle
    in_v = 4'b0001; step();
    chk("rt h1 rise", b_rise, 1'b1);
    in_v = 4'b0000; step();
    in_v = 4'b0001; step();
    chk("rt h3 yo", b_yo, 1'b1);
    chk("rt h3 rise", b_rise, 1'b0);
    in_v = 4'b0000; steps(3);
    chk("rt extended yo", b_yo, 1'b1);
    chk("rt extended busy", b_busy, 1'b0);
    step();
    chk("rt end yo", b_yo, 1'b0);

    // AND / XOR on a
    mode = 2'b01; in_v = 4'b1111; step();
    chk("and1111 yo", a_yo, 1'b1);
    in_v = 4'b1110; step();
    chk("and1110 yo", a_yo, 1'b0);
    mode = 2'b10; in_v = 4'b0111; step();
    chk("xor0111 yo", a_yo, 1'b1);
    in_v = 4'b0110; step();
    chk("xor0110 yo", a_yo, 1'b0);

    // sticky: clear the latch armed by earlier traffic, then enter mode 11
    mode = 2'b00; in_v = 4'b0000; clr = 1'b1; step();
    clr = 1'b0; steps(6);
    mode = 2'b11; step();
    chk("stk idle yo", a_yo, 1'b0);
    in_v = 4'b0100; step();
    chk("stk set yo", a_yo, 1'b1);
    chk("stk set rise", a_rise, 1'b1);
    in_v = 4'b0000; steps(4);
    chk("stk hold yo", a_yo, 1'b1);
    chk("stk hold rise", a_rise, 1'b0);
    clr = 1'b1; step();
    chk("stk clr edge yo", a_yo, 1'b1);
    clr = 1'b0; step();
    chk("stk cleared yo", a_yo, 1'b0);
    clr = 1'b1; in_v = 4'b0001; step();
    chk("stk clr+set yo", a_yo, 1'b1);
    clr = 1'b0; in_v = 4'b0000; step();
    chk("stk clr wins yo", a_yo, 1'b0);

    // reset mid-stretch on c (STRETCH=5)
    mode = 2'b00; clr = 1'b1; step();
    clr = 1'b0; steps(8);
    in_v = 4'b0001; step();
    chk("rs load busy", c_busy, 1'b1);
    in_v = 4'b0000; steps(2);
    chk("rs cnt3 yo", c_yo, 1'b1);
    rst_n = 1'b0; #1;
    chk("rs async yo", c_yo, 1'b0);
    chk("rs async busy", c_busy, 1'b0);
    chk("rs async rise", c_rise, 1'b0);
    step();
    rst_n = 1'b1; steps(2);
    chk("rs after yo", c_yo, 1'b0);
    chk("rs after busy", c_busy, 1'b0);
    // reset on the rise cycle drops rise_o at once
    in_v = 4'b0001; step();
    chk("rs2 rise", c_rise, 1'b1);
    rst_n = 1'b0; #1;
    chk("rs2 async rise", c_rise, 1'b0);
    chk("rs2 async yo", c_yo, 1'b0);
    in_v = 4'b0000; step();
    rst_n = 1'b1; steps(2);

    // enable freeze mid-stretch on c
    in_v = 4'b0001; step();
    in_v = 4'b0000; steps(2);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en0 yo", c_yo, 1'b1);
      chk("en0 busy", c_busy, 1'b1);
      chk("en0 rise", c_rise, 1'b0);
    end
    en = 1'b1; step();
    chk("en1 cnt2 busy", c_busy, 1'b1);
    step();
    chk("en1 cnt1 busy", c_busy, 1'b1);
    step();
    chk("en1 cnt0 yo", c_yo, 1'b1);
    chk("en1 cnt0 busy", c_busy, 1'b0);
    step();
    chk("en1 end yo", c_yo, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
